// File: rtl/io_pkg.sv
// Shared register map, CTRL bit positions and timer state type for the
// memory-mapped I/O responder.
package io_pkg;

   localparam logic [9:0] LED_LO    = 10'h060;
   localparam logic [9:0] LED_HI    = 10'h062;
   localparam logic [9:0] SW_LO     = 10'h070;
   localparam logic [9:0] SW_HI     = 10'h072;
   localparam logic [9:0] TMR_CTRL  = 10'h100;
   localparam logic [9:0] TMR_LOAD  = 10'h104;
   localparam logic [9:0] TMR_COUNT = 10'h108;
   localparam logic [9:0] TMR_STAT  = 10'h10C;

   localparam int CTRL_EN = 0;
   localparam int CTRL_AR = 1;

   typedef enum logic {
      TMR_IDLE = 1'b0,
      TMR_RUN  = 1'b1
   } tmr_state_e;

   function automatic logic is_mapped(input logic [9:0] a);
      case (a)
         LED_LO, LED_HI, SW_LO, SW_HI,
         TMR_CTRL, TMR_LOAD, TMR_COUNT, TMR_STAT: return 1'b1;
         default:                                 return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/io_timer.sv
// Down-counting timer with optional auto-reload and a sticky done flag that
// clears when STATUS is read; the enable bit is the IDLE/RUN state itself.
module io_timer #(
   parameter int TMR_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ctrl_we_i,
   input  logic [1:0]           ctrl_wdata_i,
   input  logic                 load_we_i,
   input  logic [TMR_WIDTH-1:0] load_wdata_i,
   input  logic                 stat_rd_i,
   output logic                 en_o,
   output logic                 ar_o,
   output logic [TMR_WIDTH-1:0] load_o,
   output logic [TMR_WIDTH-1:0] count_o,
   output logic                 done_o
);
   import io_pkg::*;

   tmr_state_e           state_q, state_d;
   logic                 ar_q, ar_d;
   logic [TMR_WIDTH-1:0] load_q, load_d;
   logic [TMR_WIDTH-1:0] count_q, count_d;
   logic                 done_q, done_d;
   logic                 expire;

   // NOTE: every variable gets a default before any branch so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      ar_d    = ar_q;
      load_d  = load_q;
      count_d = count_q;
      done_d  = done_q;
      expire  = 1'b0;

      if (state_q == TMR_RUN) begin
         if (count_q == TMR_WIDTH'(1)) begin
            count_d = '0;
            expire  = 1'b1;
            if (!ar_q) state_d = TMR_IDLE;
         end else if (count_q == '0) begin
            // Sitting at zero while running: reload, and keep flagging if nothing useful reloads.
            count_d = ar_q ? load_q : '0;
            expire  = !ar_q || (load_q == '0);
         end else begin
            count_d = count_q - TMR_WIDTH'(1);
         end
      end

      if (load_we_i) load_d = load_wdata_i;

      // A CTRL write overrides the FSM's own en/auto-reload decision on the same edge.
      if (ctrl_we_i) begin
         ar_d    = ctrl_wdata_i[CTRL_AR];
         state_d = ctrl_wdata_i[CTRL_EN] ? TMR_RUN : TMR_IDLE;
         if (state_q == TMR_IDLE && ctrl_wdata_i[CTRL_EN]) count_d = load_q;
      end

      if (stat_rd_i) done_d = 1'b0;
      if (expire)    done_d = 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= TMR_IDLE;
         ar_q    <= 1'b0;
         load_q  <= '0;
         count_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ar_q    <= ar_d;
         load_q  <= load_d;
         count_q <= count_d;
         done_q  <= done_d;
      end
   end

   assign en_o    = (state_q == TMR_RUN);
   assign ar_o    = ar_q;
   assign load_o  = load_q;
   assign count_o = count_q;
   assign done_o  = done_q;

endmodule

// File: rtl/io_responder.sv
// I/O page responder: address decode, LED register, switch synchronizer,
// combinational read mux and registered address-error pulse around io_timer.
module io_responder #(
   parameter int LED_WIDTH = 24,
   parameter int SW_WIDTH  = 24,
   parameter int TMR_WIDTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 ioread,
   input  logic                 iowrite,
   input  logic [9:0]           addr,
   input  logic [31:0]          wdata,
   output logic [31:0]          rdata,
   input  logic [SW_WIDTH-1:0]  switch_in,
   output logic [LED_WIDTH-1:0] led_out,
   output logic                 timer_irq,
   output logic                 addr_err
);
   import io_pkg::*;

   logic [LED_WIDTH-1:0] led_q, led_d;
   logic [SW_WIDTH-1:0]  sw_meta_q, sw_sync_q;
   logic                 addr_err_q, addr_err_d;
   logic [31:0]          rd_mux;

   logic                 tmr_en, tmr_ar, tmr_done;
   logic [TMR_WIDTH-1:0] tmr_load, tmr_count;

   io_timer #(.TMR_WIDTH(TMR_WIDTH)) u_timer (
      .clock        (clock),
      .reset        (reset),
      .ctrl_we_i    (iowrite && addr == TMR_CTRL),
      .ctrl_wdata_i (wdata[1:0]),
      .load_we_i    (iowrite && addr == TMR_LOAD),
      .load_wdata_i (wdata[TMR_WIDTH-1:0]),
      .stat_rd_i    (ioread && addr == TMR_STAT),
      .en_o         (tmr_en),
      .ar_o         (tmr_ar),
      .load_o       (tmr_load),
      .count_o      (tmr_count),
      .done_o       (tmr_done)
   );

   always_comb begin
      led_d = led_q;
      if (iowrite && addr == LED_LO) led_d[15:0]           = wdata[15:0];
      if (iowrite && addr == LED_HI) led_d[LED_WIDTH-1:16] = wdata[LED_WIDTH-17:0];
   end

   assign addr_err_d = (ioread || iowrite) && (!is_mapped(addr) || addr[0]);

   always_comb begin
      rd_mux = '0;
      case (addr)
         LED_LO:    rd_mux = 32'(led_q[15:0]);
         LED_HI:    rd_mux = 32'(led_q[LED_WIDTH-1:16]);
         SW_LO:     rd_mux = 32'(sw_sync_q[15:0]);
         SW_HI:     rd_mux = 32'(sw_sync_q[SW_WIDTH-1:16]);
         TMR_CTRL:  rd_mux = 32'({tmr_ar, tmr_en});
         TMR_LOAD:  rd_mux = 32'(tmr_load);
         TMR_COUNT: rd_mux = 32'(tmr_count);
         TMR_STAT:  rd_mux = 32'(tmr_done);
         default:   rd_mux = '0;
      endcase
   end

   assign rdata = ioread ? rd_mux : 32'h0;

   always_ff @(posedge clock) begin
      if (reset) begin
         led_q      <= '0;
         sw_meta_q  <= '0;
         sw_sync_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         led_q      <= led_d;
         sw_meta_q  <= switch_in;
         sw_sync_q  <= sw_meta_q;
         addr_err_q <= addr_err_d;
      end
   end

   assign led_out   = led_q;
   assign timer_irq = tmr_done;
   assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_io_responder.sv
// Bench for io_responder: directed vector table, hand-written timer/switch
// sequences and randomized traffic against a behavioural model of the I/O page.
module tb_io_responder;
   import io_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        ioread = 1'b0;
   logic        iowrite = 1'b0;
   logic [9:0]  addr = '0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic [23:0] switch_in = '0;
   logic [23:0] led_out;
   logic        timer_irq;
   logic        addr_err;

   io_responder dut (
      .clock     (clock),
      .reset     (reset),
      .ioread    (ioread),
      .iowrite   (iowrite),
      .addr      (addr),
      .wdata     (wdata),
      .rdata     (rdata),
      .switch_in (switch_in),
      .led_out   (led_out),
      .timer_irq (timer_irq),
      .addr_err  (addr_err)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] last_rd;

   // Behavioural model of the visible I/O page state.
   logic [23:0] m_led, m_sw1, m_sw2;
   logic        m_en, m_ar, m_done, m_err;
   logic [31:0] m_load, m_count;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_led = '0; m_sw1 = '0; m_sw2 = '0;
      m_en = 1'b0; m_ar = 1'b0; m_done = 1'b0; m_err = 1'b0;
      m_load = '0; m_count = '0;
   endtask

   function automatic logic [31:0] model_rdata(input logic rd, input logic [9:0] a);
      if (!rd) return 32'h0;
      case (a)
         10'h060: return {16'h0, m_led[15:0]};
         10'h062: return {24'h0, m_led[23:16]};
         10'h070: return {16'h0, m_sw2[15:0]};
         10'h072: return {24'h0, m_sw2[23:16]};
         10'h100: return {30'h0, m_ar, m_en};
         10'h104: return m_load;
         10'h108: return m_count;
         10'h10C: return {31'h0, m_done};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
      logic        fired, n_en, n_ar, n_done;
      logic [31:0] n_count, n_load;
      fired = 1'b0; n_en = m_en; n_ar = m_ar; n_count = m_count; n_load = m_load;
      if (m_en) begin
         if (m_count == 32'd1) begin
            n_count = 32'd0; fired = 1'b1; n_en = m_ar;
         end else if (m_count == 32'd0) begin
            fired   = !m_ar || (m_load == 32'd0);
            n_count = m_ar ? m_load : 32'd0;
         end else begin
            n_count = m_count - 32'd1;
         end
      end
      n_done = m_done;
      if (rd && a == 10'h10C) n_done = 1'b0;
      if (fired) n_done = 1'b1;
      if (wr) begin
         case (a)
            10'h060: m_led[15:0]  = d[15:0];
            10'h062: m_led[23:16] = d[7:0];
            10'h100: begin
               n_ar = d[1];
               n_en = d[0];
               if (!m_en && d[0]) n_count = m_load;
            end
            10'h104: n_load = d;
            default: ;
         endcase
      end
      m_err = (rd || wr) && (!(a inside {10'h060, 10'h062, 10'h070, 10'h072,
                                         10'h100, 10'h104, 10'h108, 10'h10C}) || a[0]);
      m_sw2 = m_sw1;
      m_sw1 = switch_in;
      m_en = n_en; m_ar = n_ar; m_count = n_count; m_load = n_load; m_done = n_done;
   endtask

   // One bus cycle: rdata is sampled mid-cycle, registered outputs #1 after the edge.
   task automatic apply(input logic rd, input logic wr, input logic [9:0] a, input logic [31:0] d);
      ioread = rd; iowrite = wr; addr = a; wdata = d;
      @(negedge clock);
      last_rd = rdata;
      check("rdata_vs_model", last_rd, model_rdata(rd, a));
      @(posedge clock);
      model_step(rd, wr, a, d);
      #1;
      check("led_vs_model", {8'h0, led_out}, {8'h0, m_led});
      check("irq_vs_model", {31'h0, timer_irq}, {31'h0, m_done});
      check("err_vs_model", {31'h0, addr_err}, {31'h0, m_err});
   endtask

   task automatic rd_expect(input string name, input logic [9:0] a, input logic [31:0] exp);
      apply(1'b1, 1'b0, a, 32'h0);
      check(name, last_rd, exp);
   endtask

   task automatic do_reset();
      reset = 1'b1; ioread = 1'b0; iowrite = 1'b0;
      @(posedge clock);
      model_reset();
      #1;
      reset = 1'b0;
      check("reset_led", {8'h0, led_out}, 32'h0);
      check("reset_irq", {31'h0, timer_irq}, 32'h0);
      check("reset_err", {31'h0, addr_err}, 32'h0);
   endtask

   typedef struct {
      logic        rd;
      logic        wr;
      logic [9:0]  a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic [23:0] exp_led;
      logic        exp_err;
   } vec_t;

   vec_t        vecs[12];
   logic [9:0]  pool[12];
   logic [9:0]  ra;
   logic [31:0] rd_word;
   logic        rrd, rwr;
   int          exp_ar_seq[7];

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 10'h060, 32'h0000_1234, 32'h0,    24'h001234, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 10'h062, 32'h0000_00AB, 32'h0,    24'hAB1234, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 10'h062, 32'h0,         32'hAB,   24'hAB1234, 1'b0};
      vecs[3]  = '{1'b1, 1'b0, 10'h060, 32'h0,         32'h1234, 24'hAB1234, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 10'h0F0, 32'h0,         32'h0,    24'hAB1234, 1'b1};
      vecs[5]  = '{1'b1, 1'b0, 10'h060, 32'h0,         32'h1234, 24'hAB1234, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 10'h061, 32'h0000_FFFF, 32'h0,    24'hAB1234, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 10'h070, 32'h0000_FFFF, 32'h0,    24'hAB1234, 1'b0};
      vecs[8]  = '{1'b1, 1'b0, 10'h102, 32'h0,         32'h0,    24'hAB1234, 1'b1};
      vecs[9]  = '{1'b1, 1'b1, 10'h060, 32'h0000_5555, 32'h1234, 24'hAB5555, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 10'h060, 32'h0,         32'h5555, 24'hAB5555, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 10'h060, 32'h0,         32'h0,    24'hAB5555, 1'b0};

      pool = '{10'h060, 10'h062, 10'h070, 10'h072, 10'h100, 10'h104,
               10'h108, 10'h10C, 10'h061, 10'h0F0, 10'h102, 10'h3FE};
      exp_ar_seq = '{2, 1, 0, 2, 1, 0, 2};

      model_reset();
      repeat (2) @(posedge clock);
      #1;
      do_reset();
      rd_expect("reset_count", 10'h108, 32'h0);
      rd_expect("reset_ctrl", 10'h100, 32'h0);

      for (int i = 0; i < 12; i++) begin
         apply(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d);
         check($sformatf("vec%0d_rdata", i), last_rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_led", i), {8'h0, led_out}, {8'h0, vecs[i].exp_led});
         check($sformatf("vec%0d_err", i), {31'h0, addr_err}, {31'h0, vecs[i].exp_err});
      end

      // Switch synchronizer latency.
      switch_in = 24'h5A5A5A;
      rd_expect("sw_before_edge", 10'h070, 32'h0);
      rd_expect("sw_after_1_edge", 10'h070, 32'h0);
      rd_expect("sw_after_2_edges", 10'h070, 32'h5A5A);
      rd_expect("sw_hi", 10'h072, 32'h5A);

      // One-shot timer: 3,2,1,0 then stop.
      apply(1'b0, 1'b1, 10'h104, 32'd3);
      apply(1'b0, 1'b1, 10'h100, 32'd1);
      rd_expect("oneshot_3", 10'h108, 32'd3);
      check("oneshot_irq_early", {31'h0, timer_irq}, 32'h0);
      rd_expect("oneshot_2", 10'h108, 32'd2);
      rd_expect("oneshot_1", 10'h108, 32'd1);
      check("oneshot_irq", {31'h0, timer_irq}, 32'h1);
      rd_expect("oneshot_0", 10'h108, 32'd0);
      rd_expect("oneshot_en_clr", 10'h100, 32'd0);
      rd_expect("oneshot_hold0", 10'h108, 32'd0);
      rd_expect("stat_read", 10'h10C, 32'd1);
      check("stat_cleared", {31'h0, timer_irq}, 32'h0);
      rd_expect("stat_reread", 10'h10C, 32'd0);

      // Auto-reload: 2,1,0,2,1,0,...
      apply(1'b0, 1'b1, 10'h104, 32'd2);
      apply(1'b0, 1'b1, 10'h100, 32'd3);
      for (int i = 0; i < 7; i++)
         rd_expect($sformatf("ar_seq%0d", i), 10'h108, 32'(exp_ar_seq[i]));
      rd_expect("stat_at_expiry", 10'h10C, 32'd1);
      check("done_set_wins", {31'h0, timer_irq}, 32'h1);
      rd_expect("stat_no_expiry", 10'h10C, 32'd1);
      check("done_cleared", {31'h0, timer_irq}, 32'h0);
      rd_expect("ar_reloaded", 10'h108, 32'd2);

      // Reset in the middle of a count.
      apply(1'b0, 1'b1, 10'h100, 32'd0);
      apply(1'b0, 1'b1, 10'h104, 32'd8);
      apply(1'b0, 1'b1, 10'h100, 32'd1);
      rd_expect("mid_8", 10'h108, 32'd8);
      rd_expect("mid_7", 10'h108, 32'd7);
      rd_expect("mid_6", 10'h108, 32'd6);
      do_reset();
      rd_expect("mid_reset_count", 10'h108, 32'd0);
      rd_expect("mid_reset_ctrl", 10'h100, 32'd0);
      rd_expect("mid_reset_still", 10'h108, 32'd0);

      // Randomized traffic against the model.
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 9) == 0) switch_in = 24'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
         end else begin
            ra      = pool[$urandom_range(0, 11)];
            rrd     = 1'($urandom_range(0, 1));
            rwr     = ($urandom_range(0, 2) == 0);
            rd_word = $urandom;
            if (ra == 10'h104) rd_word = 32'($urandom_range(0, 6));
            apply(rrd, rwr, ra, rd_word);
         end
      end

      ioread = 1'b0; iowrite = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/io_responder.md
Name: io_responder

Overview:
- Memory-mapped I/O responder for the single-cycle MIPS core. It sits at the far end of the IORead/IOWrite strobes that the control unit raises for addresses 0xFFFFFC00–0xFFFFFFFF.
- Decodes Alu_result[9:0] and serves three devices: LED output register, synchronized switch input, and a down-counting timer with a sticky status flag.
- Supplies read data to the MemorIOtoReg writeback mux in the same cycle.

Parameters:
- LED_WIDTH, 24, width of LED output register
- SW_WIDTH, 24, width of switch input
- TMR_WIDTH, 32, timer load/count width

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clock
- ioread  in  1  I/O read strobe from control unit
- iowrite  in  1  I/O write strobe from control unit
- addr  in  10  Alu_result[9:0], byte offset within I/O page
- wdata  in  32  store data (rt value)
- rdata  out  32  load data; combinational, valid in the cycle ioread=1
- switch_in  in  SW_WIDTH  asynchronous board switches
- led_out  out  LED_WIDTH  LED register
- timer_irq  out  1  copy of status.done
- addr_err  out  1  one-cycle pulse, registered, on access to an unmapped offset

Behaviour:
- Register map (offsets):
  - 0x060 LED[15:0] RW
  - 0x062 LED[23:16] RW, zero-extended on read
  - 0x070 SW[15:0] RO
  - 0x072 SW[23:16] RO
  - 0x100 CTRL RW: bit0 en, bit1 auto-reload
  - 0x104 LOAD RW
  - 0x108 COUNT RO
  - 0x10C STATUS: bit0 done, read-to-clear
- Reset: led_out=0, CTRL=0, LOAD=0, COUNT=0, done=0, addr_err=0, both sync stages=0.
- rdata when ioread=0: 32'h0. Unused upper bits always read 0. Writes to RO offsets are ignored and raise no error.
- ioread and iowrite both 1 in one cycle: illegal; write takes effect and rdata still reflects pre-edge state.
- Switches: 2-flop synchronizer. A switch_in change is visible on rdata after 2 rising edges.
- Timer states:
  - IDLE (en=0): COUNT holds.
  - RUN: COUNT decrements by 1 per clock.
  - On the edge where COUNT==1, COUNT→0 and done←1.
  - Then: auto-reload=1 → COUNT←LOAD, stay RUN; else en←0, go IDLE.
  - COUNT==0 while RUN (LOAD=0 case): done←1 every cycle, no underflow wrap.
- CTRL write with en 0→1: COUNT←LOAD on that edge; decrement starts next edge.
- LOAD write while running: affects only the next reload.
- Same-edge events:
  - CTRL write coincident with expiry: the write wins for en/auto-reload, and done still sets.
  - STATUS read (clear) coincident with expiry: set wins, done=1.
- addr_err: set for one cycle after ioread|iowrite to an unmapped offset; also set for any offset with addr[0]=1.
- Reset mid-count: synchronous clear of all state; the timer returns to IDLE on that edge.

Decomposition:
- Package io_pkg: offset localparams (LED_LO, LED_HI, SW_LO, SW_HI, TMR_CTRL, TMR_LOAD, TMR_COUNT, TMR_STAT) and the CTRL bit indices.
- Sub-module io_timer: CTRL/LOAD/COUNT/done and the IDLE/RUN FSM, with write-enable and clear-on-read inputs.
- Top level holds decode, LED, synchronizer, rdata mux and addr_err.

Test Plan:
- Reset, then iowrite 0x060 data 0x1234, then 0x062 data 0xAB -> led_out=0xAB1234; ioread 0x062 returns 0x000000AB.
- switch_in=0x5A5A5A -> ioread 0x070 gives the old value after 1 edge and 0x5A5A after 2 edges; 0x072 gives 0x5A.
- LOAD=3, CTRL=1 -> COUNT reads 3,2,1,0 on successive cycles; done=1 and timer_irq=1 on the 0 cycle; en clears; COUNT stays 0.
- LOAD=2, CTRL=3 -> COUNT sequence 2,1,0→2,1,0…; ioread 0x10C returns 1 and done clears next edge, except on an expiry edge where it stays 1.
- ioread 0x0F0 -> rdata=0, addr_err pulses one cycle; iowrite 0x061 -> addr_err=1 and led_out unchanged.
- Timer running at COUNT=5, assert reset one cycle -> COUNT=0, CTRL=0, led_out=0, rdata at 0x108 =0.
